gpr_scoreboard_counted: RTL
===========================

Name: gpr_scoreboard_counted

Overview:
Parametrised register scoreboard for the issue stage. It generalises the single-bit SGPR/VGPR busy table to per-register outstanding-write counters, so several in-flight writes to one register are tracked instead of being lost. It also provides a configurable number of set, clear and read ports, optional clear-to-read bypass, flush, and sticky overflow/underflow error flags. One instance is used for SGPRs and one for VGPRs.

Parameters:
NUM_REGS, 512, number of tracked registers (power of two)
ADDR_W, 9, register address width; equals log2(NUM_REGS)
CNT_W, 2, outstanding-write counter width; saturates at 2^CNT_W-1
NUM_SET, 3, issue-time set ports
NUM_CLR, 3, retire-time clear ports
NUM_RD, 6, decode read ports
BYPASS_CLR, 1, 1 = read ports see same-cycle clears

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
set_valid  in  NUM_SET  per-port set strobe
set_addr  in  NUM_SET*ADDR_W  base register per set port
set_size  in  NUM_SET*2  span code: 00=1, 01=2, 1x=4 registers
clr_valid  in  NUM_CLR  per-port clear strobe
clr_addr  in  NUM_CLR*ADDR_W  base register per clear port
clr_size  in  NUM_CLR*2  span code, same encoding as set_size
flush  in  1  drop all outstanding writes (wavefront kill)
rd_valid  in  NUM_RD  read port qualifier
rd_addr  in  NUM_RD*ADDR_W  base register per read port
rd_size  in  NUM_RD*2  span code
rd_busy  out  NUM_RD*4  bit k = register base+k is busy; bits beyond the span are 0
any_busy  out  1  registered; 1 if any counter is non-zero
overflow_err  out  1  sticky; a counter increment hit saturation
underflow_err  out  1  sticky; a clear hit a zero counter

Behaviour:
- Clock domain and reset: one clock, clk. Reset is synchronous and active-high on rst. Reset zeroes all counters and clears any_busy, overflow_err and underflow_err. rd_busy is combinational, so it reads 0 one cycle after reset.
- Span decode: registers base .. base+span-1, with addresses wrapping modulo NUM_REGS. Example: base NUM_REGS-1, span 2 covers NUM_REGS-1 and 0.
- Per-register update each cycle:
  - inc = number of valid set ports covering the register.
  - dec = number of valid clear ports covering the register.
  - next = cnt + inc - dec, computed at CNT_W+2 bits.
- Saturation and errors:
  - If next exceeds the maximum, the counter holds the maximum and overflow_err sets.
  - If next is below 0, the counter becomes 0 and underflow_err sets.
  - Both flags stay set until rst.
- Simultaneous set and clear on the same register net out within the cycle. Example: cnt 1, one set and one clear gives cnt 1 with no error.
- flush has priority. Counters take next = inc only: same-cycle sets survive, clears are ignored. No error flags are raised in a flush cycle.
- Read ports:
  - busy = (cnt != 0), masked by the span and by rd_valid.
  - When BYPASS_CLR=1, a register whose cnt - dec would reach 0 this cycle reads not-busy. Same-cycle sets are never forwarded.
  - When BYPASS_CLR=0, rd_busy reflects the registered counters only.
- any_busy is the OR of all counters, registered, so it lags the update by 1 cycle.
- Latency: set or clear at cycle N is visible on rd_busy at N+1. A clear with bypass is visible at N.
- Write ports are not back-pressured. The issue logic must not exceed 2^CNT_W-1 outstanding writes per register; overflow_err is diagnostic only.

Test Plan:
- Reset with a counter preloaded: rst=1 for one cycle with counters non-zero -> all rd_busy=0, any_busy=0 and both error flags 0 on the following cycle.
- Span wrap: set port0 addr 510 size 1x, then read port0 addr 510 size 1x -> rd_busy[3:0]=1111 at N+1. Read of addr 1 size 00 -> 1. Read of addr 2 -> 0.
- Counted outstanding writes: two sets to reg 5 in consecutive cycles, then one clear -> reg 5 still busy. Second clear -> busy=0 on the next cycle (same cycle with BYPASS_CLR=1).
- Multi-port collision: set ports 0 and 1 both hit reg 7 while clear port 0 also hits reg 7, starting from cnt 0 -> cnt 1, no error flags.
- Saturation and underflow (CNT_W=2): four sets to reg 9 -> overflow_err=1 and cnt held at 3. Then a clear on a zero counter at reg 20 -> underflow_err=1 with reg 20 remaining 0.
- Flush with a concurrent set: regs 0-3 busy; flush=1 in the same cycle as a set to reg 40 -> only reg 40 busy afterwards, and any_busy=1 one cycle later.

Source files
------------

// File: rtl/gpr_scoreboard_counted_if.sv
// Bus bundle for the counted GPR scoreboard: set/clear/read ports, flush and status outputs.
// The master drives write and read requests; the slave is the scoreboard.
interface gpr_scoreboard_counted_if #(
  parameter int ADDR_W  = 9,
  parameter int NUM_SET = 3,
  parameter int NUM_CLR = 3,
  parameter int NUM_RD  = 6
);
  logic [NUM_SET-1:0]        set_valid;
  logic [NUM_SET*ADDR_W-1:0] set_addr;
  logic [NUM_SET*2-1:0]      set_size;
  logic [NUM_CLR-1:0]        clr_valid;
  logic [NUM_CLR*ADDR_W-1:0] clr_addr;
  logic [NUM_CLR*2-1:0]      clr_size;
  logic                      flush;
  logic [NUM_RD-1:0]         rd_valid;
  logic [NUM_RD*ADDR_W-1:0]  rd_addr;
  logic [NUM_RD*2-1:0]       rd_size;
  logic [NUM_RD*4-1:0]       rd_busy;
  logic                      any_busy;
  logic                      overflow_err;
  logic                      underflow_err;

  modport master (
    output set_valid, set_addr, set_size,
    output clr_valid, clr_addr, clr_size,
    output flush, rd_valid, rd_addr, rd_size,
    input  rd_busy, any_busy, overflow_err, underflow_err
  );

  modport slave (
    input  set_valid, set_addr, set_size,
    input  clr_valid, clr_addr, clr_size,
    input  flush, rd_valid, rd_addr, rd_size,
    output rd_busy, any_busy, overflow_err, underflow_err
  );
endinterface

// File: rtl/gpr_scoreboard_counted.sv
// Register scoreboard with per-register outstanding-write counters, multi-port set/clear/read,
// optional clear-to-read bypass, flush, and sticky saturation error flags.
module gpr_scoreboard_counted #(
  parameter int NUM_REGS   = 512,
  parameter int ADDR_W     = 9,
  parameter int CNT_W      = 2,
  parameter int NUM_SET    = 3,
  parameter int NUM_CLR    = 3,
  parameter int NUM_RD     = 6,
  parameter int BYPASS_CLR = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  gpr_scoreboard_counted_if.slave    bus
);
  localparam int              NW      = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [NW-1:0]    MAX_NW  = {2'b00, CNT_MAX};

  logic [CNT_W-1:0]     r_cnt  [NUM_REGS];
  logic                 r_any;
  logic                 r_ovf;
  logic                 r_udf;

  logic [NW-1:0]        w_inc  [NUM_REGS];
  logic [NW-1:0]        w_dec  [NUM_REGS];
  logic signed [NW-1:0] w_sum  [NUM_REGS];
  logic [CNT_W-1:0]     w_next [NUM_REGS];
  logic                 w_ovf;
  logic                 w_udf;
  logic                 w_any;
  logic [NUM_RD*4-1:0]  w_rd_busy;

  // Span code 00=1, 01=2, 1x=4 registers starting at the base.
  function automatic logic [3:0] span_mask(input logic [1:0] size);
    if (size == 2'b00)      return 4'b0001;
    else if (size == 2'b01) return 4'b0011;
    else                    return 4'b1111;
  endfunction

  // Distance from the base wraps modulo NUM_REGS through the ADDR_W-bit subtraction.
  function automatic logic covers(input logic [ADDR_W-1:0] base, input logic [1:0] size,
                                  input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - base;
    if (size == 2'b00)      return off == '0;
    else if (size == 2'b01) return off < ADDR_W'(2);
    else                    return off < ADDR_W'(4);
  endfunction

  // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_inc[r] = '0;
      w_dec[r] = '0;
      for (int s = 0; s < NUM_SET; s++)
        if (bus.set_valid[s] && covers(bus.set_addr[s*ADDR_W +: ADDR_W], bus.set_size[s*2 +: 2],
                                       ADDR_W'(r)))
          w_inc[r] = w_inc[r] + NW'(1);
      for (int c = 0; c < NUM_CLR; c++)
        if (bus.clr_valid[c] && covers(bus.clr_addr[c*ADDR_W +: ADDR_W], bus.clr_size[c*2 +: 2],
                                       ADDR_W'(r)))
          w_dec[r] = w_dec[r] + NW'(1);
    end
  end

  // Sets and clears net out first; saturation only looks at the combined result.
  always_comb begin
    w_ovf = 1'b0;
    w_udf = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_sum[r]  = $signed({2'b00, r_cnt[r]}) + $signed(w_inc[r]) - $signed(w_dec[r]);
      w_next[r] = w_sum[r][CNT_W-1:0];
      if (bus.flush) begin
        w_next[r] = (w_inc[r] > MAX_NW) ? CNT_MAX : w_inc[r][CNT_W-1:0];
      end else if (w_sum[r][NW-1]) begin
        w_next[r] = '0;
        w_udf     = 1'b1;
      end else if (w_sum[r] > $signed(MAX_NW)) begin
        w_next[r] = CNT_MAX;
        w_ovf     = 1'b1;
      end
    end
  end

  always_comb begin
    w_any = 1'b0;
    for (int r = 0; r < NUM_REGS; r++)
      w_any = w_any | (r_cnt[r] != '0);
  end

  // NOTE: the counters are architectural state and must be zeroed on reset, unlike a data RAM.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
      r_any <= 1'b0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= w_next[r];
      r_any <= w_any;
      r_ovf <= r_ovf | w_ovf;
      r_udf <= r_udf | w_udf;
    end
  end

  // A register whose pending clears cover its whole count reads free in the same cycle.
  always_comb begin
    w_rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int k = 0; k < 4; k++) begin
        logic [ADDR_W-1:0] w_reg;
        w_reg = bus.rd_addr[p*ADDR_W +: ADDR_W] + ADDR_W'(k);
        if (bus.rd_valid[p] && span_mask(bus.rd_size[p*2 +: 2])[k] && (r_cnt[w_reg] != '0))
          w_rd_busy[p*4+k] = !((BYPASS_CLR != 0) && (w_dec[w_reg] >= {2'b00, r_cnt[w_reg]}));
      end
    end
  end

  assign bus.rd_busy       = w_rd_busy;
  assign bus.any_busy      = r_any;
  assign bus.overflow_err  = r_ovf;
  assign bus.underflow_err = r_udf;
endmodule
